// File: rtl/definesPkg.sv
// Shared definitions for the branch target buffer: default depth, entry layout and counter encoding.
package definesPkg;

    localparam int BTB_ENTRIES = 16;

    // Wide enough for the tag of the smallest legal table (2 entries); narrower tags are zero-extended.
    localparam int BTB_TAG_MAX_W = 14;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [15:0]              target;
        logic [1:0]               ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational 2-bit saturating counter step used on the BTB update path.
// Only built when BTB_2BIT_COUNTER_EN is defined.
`ifdef BTB_2BIT_COUNTER_EN
module btb_sat_counter (
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != 2'b11) begin
                o_ctr = i_ctr + 2'b01;
            end
        end else if (i_ctr != 2'b00) begin
            o_ctr = i_ctr - 2'b01;
        end
    end

endmodule
`endif

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC, single-cycle training port.
// Define BTB_2BIT_COUNTER_EN to keep 2-bit direction counters; otherwise any hit predicts taken.
module branch_target_buffer
    import definesPkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc,
    output logic        o_valid,
    output logic [15:0] o_BT,
    input  logic        upd_en,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_BT,
    input  logic        upd_taken
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 15 - IDX_W;

    // Register array rather than RAM: valid bits need an async clear and the read is combinational.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [15:0]        r_target [ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
    logic [1:0]         r_ctr    [ENTRIES];
    logic [1:0]         w_ctrNext;
`endif

    logic [IDX_W-1:0] w_lkIdx;
    logic [TAG_W-1:0] w_lkTag;
    logic [IDX_W-1:0] w_upIdx;
    logic [TAG_W-1:0] w_upTag;
    btb_entry_t       w_lk;
    logic             w_lkHit;
    logic             w_upHit;

    assign w_lkIdx = i_pc[IDX_W:1];
    assign w_lkTag = i_pc[15:IDX_W+1];
    assign w_upIdx = upd_pc[IDX_W:1];
    assign w_upTag = upd_pc[15:IDX_W+1];

    // Without counters every stored entry behaves as weakly taken, so a hit always predicts.
    always_comb begin
        w_lk.valid  = r_valid[w_lkIdx];
        w_lk.tag    = BTB_TAG_MAX_W'(r_tag[w_lkIdx]);
        w_lk.target = r_target[w_lkIdx];
`ifdef BTB_2BIT_COUNTER_EN
        w_lk.ctr    = r_ctr[w_lkIdx];
`else
        w_lk.ctr    = CTR_WEAK_TAKEN;
`endif
    end

    assign w_lkHit = w_lk.valid && (w_lk.tag == BTB_TAG_MAX_W'(w_lkTag));
    assign o_valid = w_lkHit && (w_lk.ctr >= CTR_WEAK_TAKEN);
    assign o_BT    = o_valid ? w_lk.target : 16'h0000;

    assign w_upHit = r_valid[w_upIdx] && (r_tag[w_upIdx] == w_upTag);

`ifdef BTB_2BIT_COUNTER_EN
    btb_sat_counter u_satCounter (
        .i_ctr (r_ctr[w_upIdx]),
        .i_inc (upd_taken),
        .o_ctr (w_ctrNext)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
`ifdef BTB_2BIT_COUNTER_EN
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b00;
            end
`endif
        end else if (upd_en) begin
            if (upd_taken) begin
                r_valid[w_upIdx] <= 1'b1;
`ifdef BTB_2BIT_COUNTER_EN
                r_ctr[w_upIdx]   <= w_upHit ? w_ctrNext : CTR_WEAK_TAKEN;
`endif
            end else if (w_upHit) begin
`ifdef BTB_2BIT_COUNTER_EN
                r_ctr[w_upIdx]   <= w_ctrNext;
`else
                r_valid[w_upIdx] <= 1'b0;
`endif
            end
        end
    end

    // Tag and target carry no reset; a write landing during reset stays hidden behind the cleared valid.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            r_tag[w_upIdx]    <= w_upTag;
            r_target[w_upIdx] <= upd_BT;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expected lookups, a negedge monitor checks them.
// Covers both BTB_2BIT_COUNTER_EN builds.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_pc;
    logic        o_valid;
    logic [15:0] o_BT;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic [15:0] upd_BT;
    logic        upd_taken;

    typedef struct {
        logic        expValid;
        logic [15:0] expBT;
        string       name;
    } exp_t;

    exp_t scoreQ[$];
    int   vecCount  = 0;
    int   missCount = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_pc      (i_pc),
        .o_valid   (o_valid),
        .o_BT      (o_BT),
        .upd_en    (upd_en),
        .upd_pc    (upd_pc),
        .upd_BT    (upd_BT),
        .upd_taken (upd_taken)
    );

    task automatic pushExpect(input logic eV, input logic [15:0] eBT, input string name);
        exp_t e;
        e.expValid = eV;
        e.expBT    = eBT;
        e.name     = name;
        scoreQ.push_back(e);
    endtask

    // One cycle of stimulus: drive just after the rising edge, expectation is for the lookup in this cycle.
    task automatic applyStimulus(input logic rstVal, input logic [15:0] pc,
                                 input logic en, input logic [15:0] uPc, input logic [15:0] uBT,
                                 input logic tk, input logic eV, input logic [15:0] eBT,
                                 input string name);
        @(posedge clk);
        #1;
        reset     = rstVal;
        i_pc      = pc;
        upd_en    = en;
        upd_pc    = uPc;
        upd_BT    = uBT;
        upd_taken = tk;
        pushExpect(eV, eBT, name);
    endtask

    task automatic checkOutput(input exp_t e);
        vecCount++;
        if (o_valid !== e.expValid || o_BT !== e.expBT) begin
            missCount++;
            $display("[TB] FAIL %s: got valid=%0b BT=%h, expected valid=%0b BT=%h",
                     e.name, o_valid, o_BT, e.expValid, e.expBT);
        end
    endtask

    always @(negedge clk) begin
        if (scoreQ.size() > 0) begin
            checkOutput(scoreQ.pop_front());
        end
    end

    initial begin
        reset     = 1'b1;
        i_pc      = 16'h0000;
        upd_en    = 1'b0;
        upd_pc    = 16'h0000;
        upd_BT    = 16'h0000;
        upd_taken = 1'b0;

        applyStimulus(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "reset_state");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "post_reset");
        applyStimulus(0, 16'h0010, 1, 16'h0010, 16'h0040, 1, 0, 16'h0000, "same_cycle_upd");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 16'h0000, 0, 1, 16'h0040, "after_alloc");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "alias_miss");
        applyStimulus(0, 16'h0012, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "other_index");
        applyStimulus(0, 16'h0011, 0, 16'h0000, 16'h0000, 0, 1, 16'h0040, "bit0_ignored");
        applyStimulus(0, 16'h0010, 1, 16'h0030, 16'h0080, 1, 1, 16'h0040, "evict_same_cycle");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "evicted");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h0080, "alias_hit");
        applyStimulus(0, 16'h0030, 1, 16'h0050, 16'h0000, 0, 1, 16'h0080, "nt_miss_upd");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h0080, "nt_miss_nochange");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h00A0, 1, 1, 16'h0080, "retarget_upd");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, "retarget");
        applyStimulus(0, 16'h0100, 1, 16'h0100, 16'h0200, 1, 0, 16'h0000, "alloc_idx0");
        applyStimulus(0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 1, 16'h0200, "hit_idx0");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, "idx8_intact");

`ifdef BTB_2BIT_COUNTER_EN
        // Entry 0x0030 sits at counter 11 here.
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 1, 16'h00A0, "nt_upd_11to10");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, "weak_still_predicts");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 1, 16'h00A0, "nt_upd_10to01");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "nt_trained");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 0, 16'h0000, "nt_upd_01to00");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 0, 16'h0000, "nt_upd_00sat");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h00A0, 1, 0, 16'h0000, "tk_upd_00to01");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "dec_saturates");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h00A0, 1, 0, 16'h0000, "tk_upd_01to10");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, "retrained");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h00A0, 1, 1, 16'h00A0, "tk_upd_to_sat");
        end
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 1, 16'h00A0, "nt_upd_from_sat");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, "sat_still_predicts");
`else
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 1, 16'h00A0, "nt_upd_hit");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "nt_invalidate");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h0000, 0, 0, 16'h0000, "nt_upd_after_inval");
        applyStimulus(0, 16'h0030, 1, 16'h0030, 16'h00A0, 1, 0, 16'h0000, "tk_realloc_upd");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, "realloc");
`endif

        // Reset raised mid-cycle with no clock edge in between; an update is pending across the reset edge.
        @(posedge clk);
        #1;
        i_pc      = 16'h0030;
        upd_en    = 1'b1;
        upd_pc    = 16'h0100;
        upd_BT    = 16'h0300;
        upd_taken = 1'b1;
        #2;
        reset = 1'b1;
        pushExpect(0, 16'h0000, "async_reset");

        applyStimulus(1, 16'h0100, 1, 16'h0100, 16'h0300, 1, 0, 16'h0000, "reset_held");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "post_reset_idx8");
        applyStimulus(0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "post_reset_idx0");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "post_reset_other");
        applyStimulus(0, 16'h0100, 1, 16'h0100, 16'h0300, 1, 0, 16'h0000, "retrain_upd");
        applyStimulus(0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 1, 16'h0300, "retrain_after_reset");
        applyStimulus(0, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, "still_cleared");

        for (int i = 0; i < 10 && scoreQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (scoreQ.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", scoreQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer that supplies next-PC predictions to the fetch stage. Each cycle it looks up the current fetch PC and drives `o_valid`/`o_BT`, which fetch uses to select `o_BT` over PC+2 when no resolved redirect (`taken`) is active. The execute stage trains it with resolved branch outcomes through a single-cycle update port.

## Interface
- `ENTRIES`, 16: number of table entries. Must be a power of two, 2..64. `IDX_W = $clog2(ENTRIES)`.
- `clk`  in  1  clock
- `reset`  in  1  reset. One clock; reset is asynchronous and active-high.
- `i_pc`  in  16  current fetch PC (fetch's `PC` register)
- `o_valid`  out  1  prediction valid: fetch redirects to `o_BT`
- `o_BT`  out  16  predicted target; 16'h0000 whenever `o_valid`=0
- `upd_en`  in  1  resolved-branch update strobe from execute
- `upd_pc`  in  16  PC of the resolved branch
- `upd_BT`  in  16  resolved branch target
- `upd_taken`  in  1  resolved direction: 1 = taken

## Operation
- PC decomposition: bit 0 ignored (halfword-aligned); index = `pc[IDX_W:1]`; tag = `pc[15:IDX_W+1]`.
- Entry fields: valid (1), tag (15-IDX_W), target (16), ctr (2).
- Hit = entry[index(i_pc)].valid && tag match.
- Prediction: `o_valid` = hit && predict_taken(entry), where predict_taken is defined under Configuration. `o_BT` = entry target when `o_valid`=1, else 0.
- Update, when `upd_en`=1 (U = upd_pc, uhit = hit computed for U):
  - taken, uhit: target <= upd_BT; ctr saturating +1 (max 2'b11).
  - taken, miss: allocate/evict: valid<=1, tag<=tag(U), target<=upd_BT, ctr<=2'b10.
  - not taken, uhit: ctr saturating −1 (min 2'b00); entry stays valid (counter mode).
  - not taken, miss: no change.
- `upd_en`=0: table unchanged.
- Table contents are otherwise unaffected by fetch's `taken` or `f_valid`; mispredict recovery is fetch's job.

## Timing
- Lookup is combinational from `i_pc` and the table state: `o_valid`/`o_BT` are valid in the same cycle `i_pc` is presented.
- Updates commit on the rising `clk` edge and are visible to lookups starting the following cycle.
- When lookup and update hit the same index in the same cycle, the lookup returns the pre-update contents.
- Reset: all valid bits and all ctr fields clear asynchronously. `o_valid`=0 and `o_BT`=0 immediately on assertion. Targets and tags need not reset. An update coincident with reset is discarded.
- There are no stalls and no handshake. One update per cycle is the maximum.

## Configuration
- `BTB_2BIT_COUNTER_EN` defined: 2-bit saturating counters are kept. predict_taken = ctr[1]. Update rules as above.
- Undefined: ctr storage is omitted and predict_taken = 1 for any hit. A not-taken update that hits invalidates the entry (valid<=0). Taken updates write valid/tag/target only.

## Structure
- `definesPkg` gains the `BTB_ENTRIES` default constant, the `btb_entry_t` packed struct (valid, tag, target, ctr), and the `CTR_WEAK_TAKEN` = 2'b10 constant.
- Sub-module `btb_sat_counter`: combinational 2-bit saturating next-state (inc/dec). It is instantiated once on the update path and is present only under `BTB_2BIT_COUNTER_EN`.
- The table is an array of registers (not inferred RAM), because both the asynchronous valid clear and the combinational read are required.

## Test plan
ENTRIES=16; 0x0010 and 0x0030 share index 8 with different tags.
- Reset, then `i_pc`=0x0010 -> `o_valid`=0, `o_BT`=0x0000.
- Taken update 0x0010->0x0040; next cycle `i_pc`=0x0010 -> `o_valid`=1, `o_BT`=0x0040; `i_pc`=0x0030 -> `o_valid`=0.
- Same-cycle update 0x0010->0x0040 and lookup 0x0010 -> `o_valid`=0 that cycle, 1 the next.
- Alias eviction: after the previous case, taken update 0x0030->0x0080 -> lookup 0x0010 gives `o_valid`=0; lookup 0x0030 gives 1 / 0x0080.
- Direction training (macro on): taken 0x0010 (ctr 10) -> not-taken -> `o_valid`=0 (ctr 01) -> taken -> `o_valid`=1. Three more taken updates saturate at 11; one not-taken still predicts. Macro off: a single not-taken update gives `o_valid`=0.
- With entries populated, assert `reset` mid-cycle -> `o_valid` drops to 0 asynchronously. It stays 0 for all PCs after release until retrained.
